// File: rtl/div_req_arbiter.sv
// Round-robin share of one sequential divider; requests accepted only in IDLE, divide-by-zero answered directly.
// Response valid T+D_WIDTH+3 after accept (T+1 for /0); response held stable until i_rsp_ready.
module div_req_arbiter #(
    parameter int D_WIDTH = 4,
    parameter int N_REQ   = 4,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]   i_req_dividend,
    input  logic [N_REQ*D_WIDTH-1:0]   i_req_divisor,
    output logic                       o_div_start,
    output logic [D_WIDTH-1:0]         o_div_dividend,
    output logic [D_WIDTH-1:0]         o_div_divisor,
    input  logic                       i_div_done,
    input  logic [D_WIDTH-1:0]         i_div_quotient,
    input  logic [D_WIDTH-1:0]         i_div_remainder,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic [D_WIDTH-1:0]         o_rsp_quotient,
    output logic [D_WIDTH-1:0]         o_rsp_remainder,
    output logic                       o_rsp_dbz,
    output logic                       o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    r_id;
    logic [D_WIDTH-1:0] r_dvd;
    logic [D_WIDTH-1:0] r_dvs;
    logic [D_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_r;
    logic               r_dbz;

    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_idx;
    logic [ID_W-1:0]    w_k;
    logic [D_WIDTH-1:0] w_sel_dvd;
    logic [D_WIDTH-1:0] w_sel_dvs;

    // First valid requester searching upward from the one after the last grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_k         = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_k = ID_W'((int'(r_last) + i) % N_REQ);
            if (!w_grant_vld && i_req_valid[w_k]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_k;
            end
        end
    end

    assign w_sel_dvd = i_req_dividend[w_grant_idx*D_WIDTH +: D_WIDTH];
    assign w_sel_dvs = i_req_divisor[w_grant_idx*D_WIDTH +: D_WIDTH];

    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && !i_rst && w_grant_vld) begin
            o_req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_last  <= ID_W'(N_REQ - 1);
            r_id    <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_last <= w_grant_idx;
                        r_id   <= w_grant_idx;
                        r_dvd  <= w_sel_dvd;
                        r_dvs  <= w_sel_dvs;
                        if (w_sel_dvs == '0) begin
                            r_q     <= '1;
                            r_r     <= w_sel_dvd;
                            r_dbz   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    // Divider keeps iterating after done, so only the first done cycle is trustworthy.
                    if (i_div_done) begin
                        r_q     <= i_div_quotient;
                        r_r     <= i_div_remainder;
                        r_dbz   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_div_start     = (r_state == S_START);
    assign o_div_dividend  = r_dvd;
    assign o_div_divisor   = r_dvs;
    assign o_rsp_valid     = (r_state == S_RESP);
    assign o_rsp_id        = r_id;
    assign o_rsp_quotient  = r_q;
    assign o_rsp_remainder = r_r;
    assign o_rsp_dbz       = r_dbz;
    assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_req_arbiter.sv
// Bench for div_req_arbiter: directed requests, a small divider model and a cycle-level reference model.
module tb_div_req_arbiter;
    localparam int D  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*D-1:0] req_dvd;
    logic [N*D-1:0] req_dvs;
    logic           div_start;
    logic [D-1:0]   div_dvd;
    logic [D-1:0]   div_dvs;
    logic           div_done = 1'b0;
    logic [D-1:0]   div_q = '0;
    logic [D-1:0]   div_r = '0;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [D-1:0]   rsp_q;
    logic [D-1:0]   rsp_r;
    logic           rsp_dbz;
    logic           busy;

    div_req_arbiter #(.D_WIDTH(D), .N_REQ(N)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_dividend(req_dvd), .i_req_divisor(req_dvs),
        .o_div_start(div_start), .o_div_dividend(div_dvd), .o_div_divisor(div_dvs),
        .i_div_done(div_done), .i_div_quotient(div_q), .i_div_remainder(div_r),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_quotient(rsp_q), .o_rsp_remainder(rsp_r), .o_rsp_dbz(rsp_dbz),
        .o_busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider: done rises D edges after start, then keeps scrambling its outputs.
    logic         dv_run = 1'b0;
    int           dv_cnt = 0;
    logic [D-1:0] dv_dvd = '0;
    always @(posedge clk) begin
        if (div_start) begin
            dv_run   <= 1'b1;
            dv_cnt   <= 0;
            dv_dvd   <= div_dvd;
            div_done <= 1'b0;
        end else if (dv_run) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == D - 1) begin
                div_done <= 1'b1;
                if (div_dvs == '0) begin
                    div_q <= '1;
                    div_r <= dv_dvd;
                end else begin
                    div_q <= dv_dvd / div_dvs;
                    div_r <= dv_dvd % div_dvs;
                end
            end else if (dv_cnt >= D) begin
                div_q <= div_q + D'(5);
                div_r <= ~div_r;
            end
        end
    end

    // Reference model: transaction state plus cycles elapsed since acceptance.
    bit           chk_en = 1'b0;
    bit           m_busy = 1'b0;
    int           m_cyc  = 0;
    int           m_last = N - 1;
    bit           m_dbz  = 1'b0;
    int           m_id   = 0;
    int           m_dvd  = 0;
    int           m_dvs  = 0;
    int           g_m;
    logic [N-1:0] e_rdy;
    bit           e_start;
    bit           e_rv;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int pick;
        int k;
        pick = -1;
        for (int i = 1; i <= N; i++) begin
            k = (last + i) % N;
            if (pick < 0 && v[k[IW-1:0]]) pick = k;
        end
        return pick;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy   = '0;
            e_start = 1'b0;
            e_rv    = 1'b0;
            g_m     = rr_pick(m_last, req_valid);
            if (!m_busy) begin
                if (g_m >= 0 && !rst) e_rdy[g_m[IW-1:0]] = 1'b1;
            end else begin
                e_start = !m_dbz && (m_cyc == 1);
                e_rv    = m_dbz ? 1'b1 : (m_cyc >= D + 3);
            end
            chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
            chk("m_div_start", 32'(div_start), 32'(e_start));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("m_busy", 32'(busy), 32'(m_busy));
            if (m_busy && !m_dbz && m_cyc >= 1 && m_cyc <= D + 2)
                chk("m_div_divisor", 32'(div_dvs), 32'(m_dvs));
            if (e_start) chk("m_div_dividend", 32'(div_dvd), 32'(m_dvd));
            if (e_rv) begin
                chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("m_rsp_q", 32'(rsp_q), m_dbz ? 32'((1 << D) - 1) : 32'(m_dvd / m_dvs));
                chk("m_rsp_r", 32'(rsp_r), m_dbz ? 32'(m_dvd) : 32'(m_dvd % m_dvs));
                chk("m_rsp_dbz", 32'(rsp_dbz), 32'(m_dbz));
            end
            if (rst) begin
                m_busy = 1'b0;
                m_last = N - 1;
            end else if (m_busy) begin
                if (e_rv && rsp_ready) m_busy = 1'b0;
                else m_cyc++;
            end else if (g_m >= 0) begin
                m_busy = 1'b1;
                m_cyc  = 1;
                m_last = g_m;
                m_id   = g_m;
                m_dvd  = int'(req_dvd[g_m*D +: D]);
                m_dvs  = int'(req_dvs[g_m*D +: D]);
                m_dbz  = (m_dvs == 0);
            end
        end
    end

    task automatic set_op(input int p, input int dvd, input int dvs);
        req_dvd[p*D +: D] = D'(dvd);
        req_dvs[p*D +: D] = D'(dvs);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) break;
        end
        if (rsp_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid still 0, want 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int t = 0; t < 40 && idx < 0; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (req_ready[k] === 1'b1) idx = k;
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: no req_ready, want a grant (cycle %0d)", cyc);
        end
    endtask

    // Issues one request from IDLE and checks the response literally; leaves the bench in the response cycle.
    task automatic run_req(input int p, input int dvd, input int dvs, input int exp_lat,
                           input int exp_q, input int exp_r, input int exp_dbz);
        int lat;
        int more;
        set_op(p, dvd, dvs);
        req_valid = '0;
        req_valid[p[IW-1:0]] = 1'b1;
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'(1) << p);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("start_pulse", 32'(div_start), 32'(dvs != 0));
        lat = 1;
        if (rsp_valid !== 1'b1) begin
            wait_rsp(more);
            lat += more;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_id", 32'(rsp_id), 32'(p));
        chk("rsp_q", 32'(rsp_q), 32'(exp_q));
        chk("rsp_r", 32'(rsp_r), 32'(exp_r));
        chk("rsp_dbz", 32'(rsp_dbz), 32'(exp_dbz));
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int gi;
        int lat;
        rst = 1'b1; req_valid = '0; req_dvd = '0; req_dvs = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_div", 32'({req_ready, div_start, div_dvd, div_dvs}), 32'(0));
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz}), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // All ports requesting continuously from reset.
        for (int k = 0; k < N; k++) set_op(k, 3 * k + 2, k + 1);
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(gi);
            chk("rr_order", 32'(gi), 32'(exp_order[n]));
            @(posedge clk); #1;
            if (n == 4) req_valid = '0;
            @(negedge clk);
            chk("ready_pulse", 32'(req_ready), 32'(0));
        end
        wait_rsp(lat);
        @(posedge clk); #1;

        run_req(2, 13, 4, 7, 3, 1, 0);
        @(posedge clk); #1;
        run_req(0, 9, 0, 1, 15, 9, 1);
        @(posedge clk); #1;

        // Response backpressure with a competing request pending.
        rsp_ready = 1'b0;
        run_req(3, 15, 1, 7, 15, 0, 0);
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            if (h == 0) begin
                set_op(1, 12, 5);
                req_valid = 4'b0010;
            end
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'(1));
            chk("hold_qr", 32'({rsp_q, rsp_r}), 32'(8'hF0));
            chk("hold_id", 32'(rsp_id), 32'(3));
            chk("hold_no_accept", 32'({req_ready, div_start}), 32'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("accept_after_hs", 32'(req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(lat);
        chk("pend_latency", 32'(lat), 32'(7));
        chk("pend_qr", 32'({rsp_q, rsp_r}), 32'(8'h22));
        @(posedge clk); #1;

        run_req(1, 3, 7, 7, 0, 3, 0);
        @(posedge clk); #1;
        run_req(1, 7, 2, 7, 3, 1, 0);
        @(posedge clk); #1;
        run_req(1, 8, 3, 7, 2, 2, 0);
        @(posedge clk); #1;

        // Reset while waiting on the divider.
        set_op(2, 6, 2);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_req_div", 32'({req_ready, div_start, div_dvd, div_dvs}), 32'(0));
        chk("wrst_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz}), 32'(0));
        chk("wrst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        run_req(3, 10, 3, 7, 3, 1, 0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
